// File: rtl/uart_tx_frame_gen_if.sv
// Parallel-request / serial-line bundle for the UART frame generator.
// Latency: n/a (wiring only).
// Backpressure: none carried here; busy tells the requester when a strobe would be dropped.
interface uart_tx_frame_gen_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_frame_gen.sv
// Serializes one data word per request into a UART frame (start, data LSB-first, opt. parity, stop).
// Latency: start bit appears one cycle after the accepting edge; one bit per CLK after that.
// Backpressure: none; Data_Valid outside IDLE is dropped, busy marks the frame in flight.
module uart_tx_frame_gen #(
  parameter int DATA_WIDTH    = 8,
  parameter int COUNTER_WIDTH = 4
) (
  input  logic                CLK,
  input  logic                RST,
  uart_tx_frame_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] LAST_BIT = COUNTER_WIDTH'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0]    ONE_HOT0 = DATA_WIDTH'(1);

  state_t                   state, state_nxt;
  logic [COUNTER_WIDTH-1:0] cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0]    held_data, held_data_nxt;
  logic                     held_pen, held_pen_nxt;
  logic                     held_ptyp, held_ptyp_nxt;
  logic                     tx_q, tx_nxt;
  logic                     busy_q, busy_nxt;
  logic                     data_bit;

  // Bit of the held word selected by the counter; mask form keeps every held bit in use.
  assign data_bit = |(held_data & (ONE_HOT0 << cnt));

  // Next state plus the value each state drives onto the line at the coming edge.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    held_data_nxt = held_data;
    held_pen_nxt  = held_pen;
    held_ptyp_nxt = held_ptyp;
    tx_nxt        = 1'b1;
    busy_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.Data_Valid) begin
          held_data_nxt = bus.P_DATA;
          held_pen_nxt  = bus.PAR_EN;
          held_ptyp_nxt = bus.PAR_TYP;
          state_nxt     = START;
        end
      end
      START: begin
        tx_nxt    = 1'b0;
        busy_nxt  = 1'b1;
        cnt_nxt   = '0;
        state_nxt = DATA;
      end
      DATA: begin
        tx_nxt   = data_bit;
        busy_nxt = 1'b1;
        cnt_nxt  = cnt + 1'b1;
        if (cnt == LAST_BIT) begin
          state_nxt = held_pen ? PARITY : STOP;
        end
      end
      PARITY: begin
        // Even parity is the XOR of the data; odd inverts it.
        tx_nxt    = (^held_data) ^ held_ptyp;
        busy_nxt  = 1'b1;
        state_nxt = STOP;
      end
      STOP: begin
        tx_nxt    = 1'b1;
        busy_nxt  = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, holding registers and output flops; reset abandons any frame immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= '0;
      held_data <= '0;
      held_pen  <= 1'b0;
      held_ptyp <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      held_data <= held_data_nxt;
      held_pen  <= held_pen_nxt;
      held_ptyp <= held_ptyp_nxt;
      tx_q      <= tx_nxt;
      busy_q    <= busy_nxt;
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_gen.sv
// Self-checking bench for uart_tx_frame_gen: queue-based line model plus literal frame checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx_frame_gen;

  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_frame_gen_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_frame_gen #(.DATA_WIDTH(DW), .COUNTER_WIDTH(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic tx;
    logic bsy;
  } obit_t;

  obit_t q[$];
  obit_t exp_o = 2'b10;

  int n_chk  = 0;
  int n_fail = 0;

  // Line model: an idle line accepts a request and queues the whole frame;
  // the frame's bits then appear one per edge, starting one edge later.
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      q.delete();
      exp_o = 2'b10;
    end else if (q.size() > 0) begin
      exp_o = q.pop_front();
    end else begin
      exp_o = 2'b10;
      if (bus.Data_Valid) begin
        int ones;
        ones = $countones(bus.P_DATA);
        q.push_back(2'b01);
        for (int i = 0; i < DW; i++) q.push_back({bus.P_DATA[i], 1'b1});
        if (bus.PAR_EN) begin
          // Parity bit makes the total count of ones even (TYP=0) or odd (TYP=1).
          q.push_back({(bus.PAR_TYP ? ((ones % 2) == 0) : ((ones % 2) == 1)), 1'b1});
        end
        q.push_back(2'b11);
      end
    end
  end

  task automatic tick();
    @(negedge CLK);
    n_chk++;
    if (bus.TX_OUT !== exp_o.tx || bus.busy !== exp_o.bsy) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t tx=%b busy=%b expected tx=%b busy=%b",
               $time, bus.TX_OUT, bus.busy, exp_o.tx, exp_o.bsy);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", name, act, want);
    end
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic pen, input logic pt, input logic vld);
    bus.P_DATA     = d;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = vld;
  endtask

  task automatic capture(input int n, output logic [31:0] dtx, output logic [31:0] dbz,
                         output logic [31:0] mtx, output logic [31:0] mbz);
    dtx = '0; dbz = '0; mtx = '0; mbz = '0;
    for (int j = 0; j < n; j++) begin
      tick();
      dtx = {dtx[30:0], bus.TX_OUT};
      dbz = {dbz[30:0], bus.busy};
      mtx = {mtx[30:0], exp_o.tx};
      mbz = {mbz[30:0], exp_o.bsy};
    end
  endtask

  // Request one frame with a single-cycle strobe and check the 12 samples after the accepting edge.
  task automatic one_frame(input string name, input logic [DW-1:0] d, input logic pen,
                           input logic pt, input logic [11:0] want_tx, input logic [11:0] want_bz);
    logic [31:0] dtx, dbz, mtx, mbz;
    drive(d, pen, pt, 1'b1);
    tick();
    bus.Data_Valid = 1'b0;
    capture(12, dtx, dbz, mtx, mbz);
    chk({name, "_tx"},         {20'd0, dtx[11:0]}, {20'd0, want_tx});
    chk({name, "_busy"},       {20'd0, dbz[11:0]}, {20'd0, want_bz});
    chk({name, "_model_tx"},   {20'd0, mtx[11:0]}, {20'd0, want_tx});
    chk({name, "_model_busy"}, {20'd0, mbz[11:0]}, {20'd0, want_bz});
  endtask

  initial begin
    logic [31:0] a_tx, a_bz, b_tx, b_bz, c_tx, c_bz, m_tx, m_bz;
    drive('0, 1'b0, 1'b0, 1'b0);
    RST = 1'b0;
    tick();
    tick();
    chk("reset_tx",   {31'd0, bus.TX_OUT}, 32'd1);
    chk("reset_busy", {31'd0, bus.busy},   32'd0);
    RST = 1'b1;
    tick();

    one_frame("even_a5", 8'hA5, 1'b1, 1'b0, 12'b0101_0010_1011, 12'hFFE);
    tick();
    one_frame("odd_a5",  8'hA5, 1'b1, 1'b1, 12'b0101_0010_1111, 12'hFFE);
    tick();
    one_frame("nopar_3c", 8'h3C, 1'b0, 1'b0, 12'b0001_1110_0111, 12'hFFC);
    tick();

    // Request for 0x00, a dropped 0xFF strobe at k+4, and P_DATA churn mid-frame.
    drive(8'h00, 1'b1, 1'b0, 1'b1);
    tick();
    bus.Data_Valid = 1'b0;
    capture(3, a_tx, a_bz, m_tx, m_bz);
    drive(8'hFF, 1'b0, 1'b1, 1'b1);
    capture(1, b_tx, b_bz, m_tx, m_bz);
    drive(8'h5A, 1'b0, 1'b1, 1'b0);
    capture(8, c_tx, c_bz, m_tx, m_bz);
    chk("ignore_tx",   {20'd0, a_tx[2:0], b_tx[0], c_tx[7:0]}, 32'b0000_0000_0011);
    chk("ignore_busy", {20'd0, a_bz[2:0], b_bz[0], c_bz[7:0]}, 32'hFFE);
    capture(12, a_tx, a_bz, m_tx, m_bz);
    chk("no_second_tx",   {20'd0, a_tx[11:0]}, 32'hFFF);
    chk("no_second_busy", {20'd0, a_bz[11:0]}, 32'h000);

    // Reset asserted while data bit 3 of 0xF0 is on the line.
    drive(8'hF0, 1'b1, 1'b0, 1'b1);
    tick();
    bus.Data_Valid = 1'b0;
    capture(5, a_tx, a_bz, m_tx, m_bz);
    chk("pre_reset_busy", {31'd0, a_bz[0]}, 32'd1);
    chk("pre_reset_bit3", {31'd0, a_tx[0]}, 32'd0);
    #2;
    RST = 1'b0;
    #1;
    chk("async_reset_tx",   {31'd0, bus.TX_OUT}, 32'd1);
    chk("async_reset_busy", {31'd0, bus.busy},   32'd0);
    tick();
    tick();
    RST = 1'b1;
    one_frame("after_reset_81", 8'h81, 1'b1, 1'b0, 12'b0100_0000_1011, 12'hFFE);
    tick();

    // Data_Valid held high for 30 edges: frames every 12 cycles with one idle gap.
    drive(8'h55, 1'b1, 1'b0, 1'b1);
    tick();
    capture(24, a_tx, a_bz, m_tx, m_bz);
    chk("b2b_tx",   {8'd0, a_tx[23:0]}, {8'd0, 12'h553, 12'h553});
    chk("b2b_busy", {8'd0, a_bz[23:0]}, {8'd0, 12'hFFE, 12'hFFE});
    for (int i = 0; i < 5; i++) tick();
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("b2b_drained", {30'd0, bus.busy, bus.TX_OUT}, 32'd1);

    // Random traffic with occasional asynchronous resets, checked cycle by cycle.
    for (int i = 0; i < 2000; i++) begin
      drive(DW'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 299) == 0) begin
        #2;
        RST = 1'b0;
        tick();
        RST = 1'b1;
      end else begin
        tick();
      end
    end
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_gen.md
# uart_tx_frame_gen

UART transmitter frame generator. Accepts a parallel data word with a single-cycle valid strobe and serializes it onto `TX_OUT` as one UART frame: start bit, data LSB-first, optional parity bit, and stop bit. Transmits one bit per `CLK` cycle, so `CLK` is the TX baud clock. It is the transmit-side counterpart of the UART RX chain and uses the same parity convention as RX parity checking.

## Interface
- `DATA_WIDTH`, default 8: frame data bits; legal range 2..15.
- `COUNTER_WIDTH`, default 4: internal bit-index counter width; must satisfy 2^COUNTER_WIDTH > DATA_WIDTH.

- `CLK`  input  1  TX baud clock; all state changes on the rising edge.
- `RST`  input  1  asynchronous active-low reset.
- `P_DATA`  input  DATA_WIDTH  data word to send.
- `Data_Valid`  input  1  request strobe; sampled on rising `CLK` edges.
- `PAR_EN`  input  1  1 = frame includes a parity bit.
- `PAR_TYP`  input  1  0 = even parity, 1 = odd parity.
- `TX_OUT`  output  1  serial line; idle level is 1; registered.
- `busy`  output  1  high while a frame is in flight; registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE
  - `TX_OUT` = 1, `busy` = 0.
  - If `Data_Valid` = 1, capture `P_DATA`, `PAR_EN`, and `PAR_TYP` into holding registers, then go to START.
- START: `TX_OUT` = 0, clear the bit counter, then go to DATA.
- DATA
  - `TX_OUT` = held_data[bit_counter]; increment the counter.
  - After bit DATA_WIDTH-1, go to PARITY if held `PAR_EN` = 1, otherwise go to STOP.
- PARITY
  - `TX_OUT` = (^held_data) when held `PAR_TYP` = 0.
  - `TX_OUT` = ~(^held_data) when held `PAR_TYP` = 1.
  - Then go to STOP.
- STOP: `TX_OUT` = 1, then go to IDLE.
- `busy` = 1 in START, DATA, PARITY, and STOP.
- Requests are accepted only in IDLE. `Data_Valid` in any other state is ignored and dropped, not queued.
- Changes on `P_DATA`, `PAR_EN`, or `PAR_TYP` after acceptance have no effect on the frame in flight.
- Reset, including mid-frame:
  - Forces IDLE, `TX_OUT` = 1, `busy` = 0, counter = 0, and holding registers = 0.
  - Takes effect immediately and asynchronously. The partial frame is abandoned with no stop bit emitted.
  - After reset release, the first rising edge with `Data_Valid` = 1 is accepted.

## Timing
- `Data_Valid` sampled high in IDLE at edge k:
  - Start bit is on `TX_OUT` from edge k+1, and `busy` rises at edge k+1.
  - Data bit i occupies cycle k+2+i.
- Frame length is DATA_WIDTH + 2 + `PAR_EN` cycles, i.e. 11 cycles for 8 data bits with parity, 10 without.
- `busy` falls and `TX_OUT` stays 1 at the edge after the stop cycle.
- `Data_Valid` held continuously high gives back-to-back frames separated by exactly one idle cycle (`TX_OUT` = 1).
- All outputs come straight from flops. There is no combinational path from inputs to outputs.

## Test plan
- Even parity:
  - Stimulus: reset, then `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, one-cycle `Data_Valid`.
  - Required: `TX_OUT` = 0,1,0,1,0,0,1,0,1,0,1 on cycles k+1..k+11.
  - Required: `busy` high for exactly 11 cycles, then `TX_OUT`=1 and `busy`=0.
- Odd parity:
  - Stimulus: same as above with `PAR_TYP`=1.
  - Required: parity bit (cycle k+10) = 1, all other bits identical.
- No parity:
  - Stimulus: `P_DATA`=0x3C, `PAR_EN`=0.
  - Required: `TX_OUT` = 0,0,0,1,1,1,1,0,0,1 over 10 cycles.
  - Required: `busy` low at k+11.
- Ignored request and input changes:
  - Stimulus: `Data_Valid` pulsed with 0xFF at cycle k+4 of a frame carrying 0x00, and `P_DATA` changed mid-frame.
  - Required: all transmitted data bits are 0; no second frame follows.
- Mid-frame reset:
  - Stimulus: assert `RST` low during data bit 3.
  - Required: `TX_OUT`=1 and `busy`=0 immediately, before the next edge.
  - Required: after release, a new 0x81 request transmits a correct complete frame.
- Back-to-back requests:
  - Stimulus: `Data_Valid` held high for 30 cycles with 0x55, `PAR_EN`=1, `PAR_TYP`=0.
  - Required: consecutive 11-cycle frames, each followed by exactly one idle-high cycle.
  - Required: parity bit = 0 in each frame.
